// File: rtl/ex_result_skid_if.sv
// ---------------------------------------------------------------------------
// ex_result_skid_if
//
// Purpose:
//   Groups the valid/ready handshake and payload buses around the execute-stage
//   result skid buffer. The upstream side carries the functional-unit result
//   into the buffer and the downstream side presents the held entry to the
//   memory stage.
//
// Signals:
//   in_valid   - FU result on in_* is valid this cycle
//   in_ready   - buffer can accept an entry this cycle (flop output)
//   in_result  - FU result, size bits
//   in_flags   - {C,V,N,Z} from the FU
//   in_rd      - destination register index, RD_W bits
//   in_we      - register write enable
//   out_valid  - out_* hold a valid entry
//   out_ready  - memory stage accepts the entry this cycle
//   out_result - held result
//   out_flags  - held {C,V,N,Z}
//   out_rd     - held destination index
//   out_we     - held write enable, forced to 0 while out_valid is 0
//
// Modports:
//   slave  - the skid buffer itself (consumes in_*, produces out_*)
//   master - the surrounding pipeline (produces in_*, consumes out_*)
// ---------------------------------------------------------------------------
interface ex_result_skid_if #(
    parameter int size = 32,
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [size-1:0] in_result;
    logic [3:0]      in_flags;
    logic [RD_W-1:0] in_rd;
    logic            in_we;

    logic            out_valid;
    logic            out_ready;
    logic [size-1:0] out_result;
    logic [3:0]      out_flags;
    logic [RD_W-1:0] out_rd;
    logic            out_we;

    // View taken by the skid buffer.
    modport slave (
        input  in_valid, in_result, in_flags, in_rd, in_we, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_rd, out_we
    );

    // View taken by the execute/memory stages around the buffer.
    modport master (
        output in_valid, in_result, in_flags, in_rd, in_we, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_rd, out_we
    );
endinterface

// File: rtl/ex_result_skid.sv
// ---------------------------------------------------------------------------
// ex_result_skid
//
// Purpose:
//   Registered output stage behind the execute-stage functional unit. Holds
//   the FU result, flags, destination tag and write enable and hands them to
//   the memory stage over valid/ready. A two-entry skid buffer keeps full
//   throughput while in_ready comes straight from a flop, so out_ready never
//   reaches back into execute combinationally.
//
// Ports:
//   i_clk    - system clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_flush  - synchronous flush, discards every held entry
//   bus      - handshake/payload interface (slave modport), see
//              ex_result_skid_if for the individual signals
// ---------------------------------------------------------------------------
module ex_result_skid #(
    parameter int size = 32,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    ex_result_skid_if.slave bus
);

    // Occupancy encoded as {main_v, skid_v}; 2'b01 has no name and is never
    // entered, so the skid entry can never exist without a main entry.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t          r_state;
    logic            r_inReady;

    logic [size-1:0] r_mainResult;
    logic [3:0]      r_mainFlags;
    logic [RD_W-1:0] r_mainRd;
    logic            r_mainWe;

    logic [size-1:0] r_skidResult;
    logic [3:0]      r_skidFlags;
    logic [RD_W-1:0] r_skidRd;
    logic            r_skidWe;

    logic            w_mainValid;
    logic            w_accept;
    logic            w_take;

    // Handshake qualifiers. accept uses the registered in_ready, so an input
    // offered while the skid slot is occupied is simply not consumed.
    assign w_mainValid = r_state[1];
    assign w_accept    = bus.in_valid & r_inReady;
    assign w_take      = w_mainValid & bus.out_ready;

    // Outputs come straight from the main register; the write enable is
    // masked so a stale we bit can never escape while nothing is valid.
    assign bus.in_ready   = r_inReady;
    assign bus.out_valid  = w_mainValid;
    assign bus.out_result = r_mainResult;
    assign bus.out_flags  = r_mainFlags;
    assign bus.out_rd     = r_mainRd;
    assign bus.out_we     = r_mainWe & w_mainValid;

    // Occupancy FSM and payload registers. in_ready is kept as its own flop
    // and always written together with the state so it equals ~skid_v on
    // every cycle. A flush empties both slots and drops any same-cycle
    // accept; a same-cycle take has already been seen downstream, so it
    // needs no extra handling. Payload registers only load on accept or on
    // the skid-to-main move, which keeps out_* steady while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= EMPTY;
            r_inReady    <= 1'b1;
            r_mainResult <= '0;
            r_mainFlags  <= '0;
            r_mainRd     <= '0;
            r_mainWe     <= 1'b0;
            r_skidResult <= '0;
            r_skidFlags  <= '0;
            r_skidRd     <= '0;
            r_skidWe     <= 1'b0;
        end else if (i_flush) begin
            r_state   <= EMPTY;
            r_inReady <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state      <= ONE;
                        r_mainResult <= bus.in_result;
                        r_mainFlags  <= bus.in_flags;
                        r_mainRd     <= bus.in_rd;
                        r_mainWe     <= bus.in_we;
                    end
                end
                ONE: begin
                    if (w_accept && w_take) begin
                        r_mainResult <= bus.in_result;
                        r_mainFlags  <= bus.in_flags;
                        r_mainRd     <= bus.in_rd;
                        r_mainWe     <= bus.in_we;
                    end else if (w_accept) begin
                        r_state      <= FULL;
                        r_inReady    <= 1'b0;
                        r_skidResult <= bus.in_result;
                        r_skidFlags  <= bus.in_flags;
                        r_skidRd     <= bus.in_rd;
                        r_skidWe     <= bus.in_we;
                    end else if (w_take) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_take) begin
                        r_state      <= ONE;
                        r_inReady    <= 1'b1;
                        r_mainResult <= r_skidResult;
                        r_mainFlags  <= r_skidFlags;
                        r_mainRd     <= r_skidRd;
                        r_mainWe     <= r_skidWe;
                    end
                end
                default: begin
                    r_state   <= EMPTY;
                    r_inReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_result_skid.sv
// ---------------------------------------------------------------------------
// tb_ex_result_skid
//
// Purpose:
//   Self-checking bench for ex_result_skid: a table of directed single-cycle
//   vectors, a hand-written asynchronous reset sequence, and a randomized
//   valid/ready phase compared against a FIFO model.
// ---------------------------------------------------------------------------
module tb_ex_result_skid;

    localparam int SIZE = 32;
    localparam int RDW  = 5;
    localparam int NVEC = 21;
    localparam int NRAND = 4000;

    logic clk;
    logic rstN;
    logic flush;

    int errors = 0;
    int checks = 0;

    ex_result_skid_if #(.size(SIZE), .RD_W(RDW)) bus ();

    ex_result_skid #(.size(SIZE), .RD_W(RDW)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_flush (flush),
        .bus     (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            inValid;
        logic [SIZE-1:0] inResult;
        logic [3:0]      inFlags;
        logic [RDW-1:0]  inRd;
        logic            inWe;
        logic            outReady;
        logic            doFlush;
        logic            expValid;
        logic            expInReady;
        logic [SIZE-1:0] expResult;
        logic [3:0]      expFlags;
        logic [RDW-1:0]  expRd;
        logic            expWe;
    } vector_t;

    typedef struct packed {
        logic [SIZE-1:0] result;
        logic [3:0]      flags;
        logic [RDW-1:0]  rd;
        logic            we;
    } entry_t;

    vector_t vec [NVEC];
    entry_t  model [$];

    // Builds one table row: inputs first, then the outputs expected just
    // after the following rising edge.
    function automatic vector_t mk(
        input logic iv, input logic [SIZE-1:0] ir, input logic [3:0] ifl,
        input logic [RDW-1:0] ird, input logic iwe, input logic ordy,
        input logic fl, input logic ev, input logic erdy,
        input logic [SIZE-1:0] er, input logic [3:0] efl,
        input logic [RDW-1:0] erd, input logic ewe);
        vector_t v;
        v.inValid = iv;   v.inResult = ir;    v.inFlags = ifl;
        v.inRd = ird;     v.inWe = iwe;       v.outReady = ordy;
        v.doFlush = fl;   v.expValid = ev;    v.expInReady = erdy;
        v.expResult = er; v.expFlags = efl;   v.expRd = erd;
        v.expWe = ewe;
        return v;
    endfunction

    // Drives every upstream/downstream input from a table row.
    task automatic applyStimulus(input vector_t v);
        bus.in_valid  = v.inValid;
        bus.in_result = v.inResult;
        bus.in_flags  = v.inFlags;
        bus.in_rd     = v.inRd;
        bus.in_we     = v.inWe;
        bus.out_ready = v.outReady;
        flush         = v.doFlush;
    endtask

    // Single comparison point: counts and reports one check.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Compares the DUT outputs with a table row; payload is only meaningful
    // while out_valid is expected high.
    task automatic checkVector(input int idx, input vector_t v);
        checkOutput($sformatf("v%0d_out_valid", idx), 64'(bus.out_valid), 64'(v.expValid));
        checkOutput($sformatf("v%0d_in_ready", idx), 64'(bus.in_ready), 64'(v.expInReady));
        checkOutput($sformatf("v%0d_out_we", idx), 64'(bus.out_we), 64'(v.expWe));
        if (v.expValid) begin
            checkOutput($sformatf("v%0d_out_result", idx), 64'(bus.out_result), 64'(v.expResult));
            checkOutput($sformatf("v%0d_out_flags", idx), 64'(bus.out_flags), 64'(v.expFlags));
            checkOutput($sformatf("v%0d_out_rd", idx), 64'(bus.out_rd), 64'(v.expRd));
        end
    endtask

    task automatic idleInputs();
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_flags  = '0;
        bus.in_rd     = '0;
        bus.in_we     = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    // Watchdog so the run always ends even if a wait never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        entry_t front;
        entry_t pushed;
        logic   acc;
        logic   tk;
        logic   prevStall;
        logic [SIZE-1:0] prevResult;
        logic [3:0]      prevFlags;
        logic [RDW-1:0]  prevRd;
        logic            prevWe;

        // Directed table: stream, backpressure, ignored input while full,
        // flush from FULL, flush with accept, restart after flush.
        vec[0]  = mk(1, 32'h11, 4'h1, 5'd1, 1, 1, 0,  1, 1, 32'h11, 4'h1, 5'd1, 1);
        vec[1]  = mk(1, 32'h22, 4'h2, 5'd2, 1, 1, 0,  1, 1, 32'h22, 4'h2, 5'd2, 1);
        vec[2]  = mk(1, 32'h33, 4'h3, 5'd3, 1, 1, 0,  1, 1, 32'h33, 4'h3, 5'd3, 1);
        vec[3]  = mk(1, 32'h44, 4'h4, 5'd4, 1, 1, 0,  1, 1, 32'h44, 4'h4, 5'd4, 1);
        vec[4]  = mk(0, 32'h0,  4'h0, 5'd0, 0, 1, 0,  0, 1, 32'h0,  4'h0, 5'd0, 0);
        vec[5]  = mk(1, 32'hAAAA_0001, 4'h8, 5'd5, 1, 0, 0,  1, 1, 32'hAAAA_0001, 4'h8, 5'd5, 1);
        vec[6]  = mk(1, 32'hAAAA_0002, 4'h4, 5'd6, 0, 0, 0,  1, 0, 32'hAAAA_0001, 4'h8, 5'd5, 1);
        vec[7]  = mk(1, 32'hDEAD_BEEF, 4'hF, 5'd31, 1, 0, 0, 1, 0, 32'hAAAA_0001, 4'h8, 5'd5, 1);
        vec[8]  = mk(1, 32'hDEAD_BEEF, 4'hF, 5'd31, 1, 0, 0, 1, 0, 32'hAAAA_0001, 4'h8, 5'd5, 1);
        vec[9]  = mk(1, 32'hDEAD_BEEF, 4'hF, 5'd31, 1, 0, 0, 1, 0, 32'hAAAA_0001, 4'h8, 5'd5, 1);
        vec[10] = mk(1, 32'hDEAD_BEEF, 4'hF, 5'd31, 1, 1, 0, 1, 1, 32'hAAAA_0002, 4'h4, 5'd6, 0);
        vec[11] = mk(0, 32'h0,  4'h0, 5'd0, 0, 1, 0,  0, 1, 32'h0,  4'h0, 5'd0, 0);
        vec[12] = mk(1, 32'hB1, 4'h2, 5'd7, 1, 0, 0,  1, 1, 32'hB1, 4'h2, 5'd7, 1);
        vec[13] = mk(1, 32'hB2, 4'h3, 5'd8, 1, 0, 0,  1, 0, 32'hB1, 4'h2, 5'd7, 1);
        vec[14] = mk(1, 32'hB3, 4'h5, 5'd10, 1, 0, 1, 0, 1, 32'h0,  4'h0, 5'd0, 0);
        vec[15] = mk(1, 32'h5,  4'h6, 5'd9, 1, 0, 0,  1, 1, 32'h5,  4'h6, 5'd9, 1);
        vec[16] = mk(0, 32'h0,  4'h0, 5'd0, 0, 0, 0,  1, 1, 32'h5,  4'h6, 5'd9, 1);
        vec[17] = mk(1, 32'h66, 4'h7, 5'd11, 1, 1, 1, 0, 1, 32'h0,  4'h0, 5'd0, 0);
        vec[18] = mk(0, 32'h0,  4'h0, 5'd0, 0, 0, 0,  0, 1, 32'h0,  4'h0, 5'd0, 0);
        vec[19] = mk(1, 32'h77, 4'h9, 5'd12, 0, 1, 0, 1, 1, 32'h77, 4'h9, 5'd12, 0);
        vec[20] = mk(0, 32'h0,  4'h0, 5'd0, 0, 1, 0,  0, 1, 32'h0,  4'h0, 5'd0, 0);

        // Power-on reset and reset-state checks.
        idleInputs();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_out_we", 64'(bus.out_we), 64'd0);
        checkOutput("reset_out_result", 64'(bus.out_result), 64'd0);
        checkOutput("reset_out_flags", 64'(bus.out_flags), 64'd0);
        checkOutput("reset_out_rd", 64'(bus.out_rd), 64'd0);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rstN = 1'b1;

        // Table phase: drive at negedge, check just after the next rise.
        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk);
            applyStimulus(vec[i]);
            @(posedge clk);
            #1;
            checkVector(i, vec[i]);
        end

        // Asynchronous reset between edges while holding one entry.
        @(negedge clk);
        idleInputs();
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h1234;
        bus.in_flags  = 4'b1010;
        bus.in_rd     = 5'd3;
        bus.in_we     = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arst_pre_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("arst_pre_result", 64'(bus.out_result), 64'h1234);
        checkOutput("arst_pre_flags", 64'(bus.out_flags), 64'hA);
        bus.in_valid = 1'b0;
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("arst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("arst_out_we", 64'(bus.out_we), 64'd0);
        checkOutput("arst_out_result", 64'(bus.out_result), 64'd0);
        checkOutput("arst_out_flags", 64'(bus.out_flags), 64'd0);
        checkOutput("arst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arst_post_valid", 64'(bus.out_valid), 64'd0);

        // Random phase against a FIFO model. Each negedge: check outputs
        // against the model, then choose new inputs and advance the model by
        // what the coming edge will do.
        prevStall  = 1'b0;
        prevResult = '0;
        prevFlags  = '0;
        prevRd     = '0;
        prevWe     = 1'b0;
        model.delete();
        for (int c = 0; c < NRAND; c++) begin
            @(negedge clk);
            checkOutput("rnd_out_valid", 64'(bus.out_valid), 64'(model.size() > 0));
            checkOutput("rnd_in_ready", 64'(bus.in_ready), 64'(model.size() < 2));
            checkOutput("rnd_legal_state", 64'(bus.out_valid | bus.in_ready), 64'd1);
            if (model.size() > 0) begin
                front = model[0];
                checkOutput("rnd_out_result", 64'(bus.out_result), 64'(front.result));
                checkOutput("rnd_out_flags", 64'(bus.out_flags), 64'(front.flags));
                checkOutput("rnd_out_rd", 64'(bus.out_rd), 64'(front.rd));
                checkOutput("rnd_out_we", 64'(bus.out_we), 64'(front.we));
            end else begin
                checkOutput("rnd_out_we_idle", 64'(bus.out_we), 64'd0);
            end
            if (prevStall) begin
                checkOutput("rnd_stable_result", 64'(bus.out_result), 64'(prevResult));
                checkOutput("rnd_stable_flags", 64'(bus.out_flags), 64'(prevFlags));
                checkOutput("rnd_stable_rd", 64'(bus.out_rd), 64'(prevRd));
                checkOutput("rnd_stable_we", 64'(bus.out_we), 64'(prevWe));
            end

            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_result = $urandom();
            bus.in_flags  = 4'($urandom_range(0, 15));
            bus.in_rd     = 5'($urandom_range(0, 31));
            bus.in_we     = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 63) == 0);

            acc = bus.in_valid & bus.in_ready;
            tk  = bus.out_valid & bus.out_ready;
            prevStall  = bus.out_valid & ~bus.out_ready & ~flush;
            prevResult = bus.out_result;
            prevFlags  = bus.out_flags;
            prevRd     = bus.out_rd;
            prevWe     = bus.out_we;

            if (flush) begin
                model.delete();
            end else begin
                if (tk) void'(model.pop_front());
                if (acc) begin
                    pushed.result = bus.in_result;
                    pushed.flags  = bus.in_flags;
                    pushed.rd     = bus.in_rd;
                    pushed.we     = bus.in_we;
                    model.push_back(pushed);
                end
            end
        end

        @(negedge clk);
        idleInputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
